// File: rtl/lcd_rx_monitor.sv
// -----------------------------------------------------------------------------
// lcd_rx_monitor
//
// Receive-side checker for a parallel RGB565 LCD interface. It watches
// HSYNC/VSYNC/DEN/RGB exactly as the video output drives them and, for each
// frame, measures line and frame timing, counts active pixels and lines and
// sums the pixel words. The results are compared against the expected timing.
// Runs on the pixel clock, either in a loopback bench or as an on-chip tap.
//
// Ports
//   lcd_clk_i     pixel clock, all logic on the rising edge
//   rst_n_i       asynchronous active-low reset (release is synchronous)
//   lcd_hsync_i   horizontal sync, asserted level given by SYNC_POL
//   lcd_vsync_i   vertical sync, asserted level given by SYNC_POL
//   lcd_den_i     data enable, 1 = valid pixel
//   lcd_r/g/b_i   RGB565 pixel components
//   err_clr_i     level, clears err_o in any cycle that sets no new error
//   frame_done_o  one-cycle pulse; the result outputs change in this cycle
//   h_active_o    DEN count of the last active line of the last frame
//   v_active_o    lines with a nonzero DEN count in the last frame
//   h_total_o     clocks in the last complete line of the last frame
//   v_total_o     hsync edges in the last frame
//   csum_o        wrapping 16-bit sum of the {r,g,b} words of the last frame
//   err_o         sticky mismatch flags: [0] h_active [1] v_active
//                 [2] h_total [3] v_total
//   locked_o      the last completed frame had no mismatch
// -----------------------------------------------------------------------------
module lcd_rx_monitor #(
   parameter int H_ACTIVE = 480,
   parameter int V_ACTIVE = 272,
   parameter int H_TOTAL  = 525,
   parameter int V_TOTAL  = 288,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        lcd_clk_i,
   input  logic        rst_n_i,
   input  logic        lcd_hsync_i,
   input  logic        lcd_vsync_i,
   input  logic        lcd_den_i,
   input  logic [4:0]  lcd_r_i,
   input  logic [5:0]  lcd_g_i,
   input  logic [4:0]  lcd_b_i,
   input  logic        err_clr_i,
   output logic        frame_done_o,
   output logic [10:0] h_active_o,
   output logic [9:0]  v_active_o,
   output logic [10:0] h_total_o,
   output logic [9:0]  v_total_o,
   output logic [15:0] csum_o,
   output logic [3:0]  err_o,
   output logic        locked_o
);

   localparam logic [10:0] EXP_H_ACT = 11'(H_ACTIVE);
   localparam logic [9:0]  EXP_V_ACT = 10'(V_ACTIVE);
   localparam logic [10:0] EXP_H_TOT = 11'(H_TOTAL);
   localparam logic [9:0]  EXP_V_TOT = 10'(V_TOTAL);

   typedef enum logic {
      SEARCH = 1'b0,
      FRAME  = 1'b1
   } state_t;

   state_t      state;

   // Input stage; syncs are normalised so that 1 always means asserted.
   logic        hs_s, vs_s, den_s;
   logic [15:0] pix_s;
   logic        hs_d, vs_d;

   logic        line_start, frame_start;

   // Per-frame accumulators
   logic [10:0] pix_cnt, den_cnt, h_act_meas;
   logic [9:0]  line_cnt, act_lines;
   logic [15:0] csum_acc;

   // Saturating increments and values seen when the current line closes
   logic [10:0] pix_inc, den_inc, close_h_act;
   logic [9:0]  line_inc, act_inc, close_v_act;
   logic [3:0]  mism, err_set;

   always_ff @(posedge lcd_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         hs_s  <= 1'b0;
         vs_s  <= 1'b0;
         den_s <= 1'b0;
         pix_s <= '0;
         hs_d  <= 1'b0;
         vs_d  <= 1'b0;
      end else begin
         // NOTE: non-blocking, so hs_d/vs_d take the pre-edge hs_s/vs_s and
         // the two stages stay one clock apart regardless of statement order.
         hs_s  <= lcd_hsync_i ^ ~SYNC_POL;
         vs_s  <= lcd_vsync_i ^ ~SYNC_POL;
         den_s <= lcd_den_i;
         pix_s <= {lcd_r_i, lcd_g_i, lcd_b_i};
         hs_d  <= hs_s;
         vs_d  <= vs_s;
      end
   end

   assign line_start  = hs_s & ~hs_d;
   assign frame_start = vs_s & ~vs_d;

   assign pix_inc  = (&pix_cnt)   ? pix_cnt   : pix_cnt   + 11'd1;
   assign den_inc  = (&den_cnt)   ? den_cnt   : den_cnt   + 11'd1;
   assign line_inc = (&line_cnt)  ? line_cnt  : line_cnt  + 10'd1;
   assign act_inc  = (&act_lines) ? act_lines : act_lines + 10'd1;

   always_comb begin
      // NOTE: defaults come first so no path leaves a signal unassigned,
      // which would otherwise infer a latch.
      close_h_act = h_act_meas;
      close_v_act = act_lines;
      mism        = '0;
      err_set     = '0;
      if (den_cnt != '0) begin
         close_h_act = den_cnt;
         close_v_act = act_inc;
      end
      // A frame without any pixel data leaves close_h_act at 0, which is
      // reported as an h_active mismatch.
      mism[0] = (close_h_act != EXP_H_ACT);
      mism[1] = (close_v_act != EXP_V_ACT);
      mism[2] = (pix_inc     != EXP_H_TOT);
      mism[3] = (line_cnt    != EXP_V_TOT);
      if (state == FRAME && frame_start) begin
         err_set = mism;
      end
   end

   always_ff @(posedge lcd_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state        <= SEARCH;
         pix_cnt      <= '0;
         den_cnt      <= '0;
         line_cnt     <= '0;
         act_lines    <= '0;
         csum_acc     <= '0;
         h_act_meas   <= '0;
         frame_done_o <= 1'b0;
         h_active_o   <= '0;
         v_active_o   <= '0;
         h_total_o    <= '0;
         v_total_o    <= '0;
         csum_o       <= '0;
         locked_o     <= 1'b0;
      end else begin
         frame_done_o <= 1'b0;
         case (state)
            SEARCH: begin
               // The frame already in progress is partial: start counting at
               // its first vsync edge and report nothing for it.
               if (frame_start) begin
                  state      <= FRAME;
                  pix_cnt    <= '0;
                  den_cnt    <= '0;
                  line_cnt   <= line_start ? 10'd1 : 10'd0;
                  act_lines  <= '0;
                  csum_acc   <= '0;
                  h_act_meas <= '0;
               end
            end

            FRAME: begin
               pix_cnt <= pix_inc;
               if (den_s) begin
                  den_cnt  <= den_inc;
                  csum_acc <= csum_acc + pix_s;
               end

               // A frame start always closes the line in progress.
               if (line_start || frame_start) begin
                  pix_cnt  <= '0;
                  den_cnt  <= '0;
                  line_cnt <= line_inc;
                  if (den_cnt != '0) begin
                     act_lines  <= act_inc;
                     h_act_meas <= den_cnt;
                  end
               end

               if (frame_start) begin
                  frame_done_o <= 1'b1;
                  h_active_o   <= close_h_act;
                  v_active_o   <= close_v_act;
                  // The closing line is the last complete line of the frame,
                  // and its edge cycle counts, hence pix_inc.
                  h_total_o    <= pix_inc;
                  v_total_o    <= line_cnt;
                  csum_o       <= csum_acc;
                  locked_o     <= (mism == '0);
                  // A coincident hsync edge is line 1 of the new frame.
                  line_cnt     <= line_start ? 10'd1 : 10'd0;
                  act_lines    <= '0;
                  csum_acc     <= '0;
                  h_act_meas   <= '0;
               end
            end

            default: state <= SEARCH;
         endcase
      end
   end

   // Sticky error flags. err_clr_i is sampled directly so that a clear and a
   // frame close in the same clock resolve here, with the new error winning.
   always_ff @(posedge lcd_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         err_o <= '0;
      end else begin
         err_o <= (err_o & ~{4{err_clr_i}}) | err_set;
      end
   end

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// -----------------------------------------------------------------------------
// tb_lcd_rx_monitor
//
// Drives a synthetic LCD stream with small timing (20 clocks x 10 lines) into
// two monitors: one with active-low syncs and one with SYNC_POL=1 fed the
// inverted syncs. Each frame is described by its line length, line count,
// active line count and DEN length; the expected results are derived from
// that description, with random pixel words summed as they are sent.
// -----------------------------------------------------------------------------
module tb_lcd_rx_monitor;

   localparam int HA = 12;
   localparam int VA = 6;
   localparam int HT = 20;
   localparam int VT = 10;

   typedef struct {
      int          h_act;
      int          v_act;
      int          h_tot;
      int          v_tot;
      logic [15:0] csum;
      logic [3:0]  mism;
      bit          clr_same;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, hs_n, vs_n, den, err_clr, inv_sel;
   logic [15:0] pix;
   logic        hs_inv, vs_inv;

   logic        d_done, i_done, d_lock, i_lock;
   logic [10:0] d_hact, i_hact, d_htot, i_htot;
   logic [9:0]  d_vact, i_vact, d_vtot, i_vtot;
   logic [15:0] d_csum, i_csum;
   logic [3:0]  d_err, i_err;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_done   = 0;
   int          n_pushed = 0;
   int          cyc      = 0;
   int          vs_drive_cyc = 0;
   bit          prev_ok  = 1'b0;
   bit          prev_done = 1'b0;
   bit          inv_check = 1'b1;
   logic [3:0]  err_model = 4'd0;
   logic        locked_model = 1'b0;
   exp_t        prev_exp;
   exp_t        mon_e;
   exp_t        exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // inv_sel = 0: the SYNC_POL=1 monitor sees correctly inverted syncs.
   assign hs_inv = hs_n ^ ~inv_sel;
   assign vs_inv = vs_n ^ ~inv_sel;

   lcd_rx_monitor #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
                    .SYNC_POL(1'b0)) dut (
      .lcd_clk_i(clk), .rst_n_i(rst_n), .lcd_hsync_i(hs_n), .lcd_vsync_i(vs_n),
      .lcd_den_i(den), .lcd_r_i(pix[15:11]), .lcd_g_i(pix[10:5]),
      .lcd_b_i(pix[4:0]), .err_clr_i(err_clr), .frame_done_o(d_done),
      .h_active_o(d_hact), .v_active_o(d_vact), .h_total_o(d_htot),
      .v_total_o(d_vtot), .csum_o(d_csum), .err_o(d_err), .locked_o(d_lock));

   lcd_rx_monitor #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
                    .SYNC_POL(1'b1)) dut_inv (
      .lcd_clk_i(clk), .rst_n_i(rst_n), .lcd_hsync_i(hs_inv), .lcd_vsync_i(vs_inv),
      .lcd_den_i(den), .lcd_r_i(pix[15:11]), .lcd_g_i(pix[10:5]),
      .lcd_b_i(pix[4:0]), .err_clr_i(err_clr), .frame_done_o(i_done),
      .h_active_o(i_hact), .v_active_o(i_vact), .h_total_o(i_htot),
      .v_total_o(i_vtot), .csum_o(i_csum), .err_o(i_err), .locked_o(i_lock));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   task automatic check_all_zero(input string who);
      check({who, "_done"},   32'(d_done), 32'd0);
      check({who, "_h_act"},  32'(d_hact), 32'd0);
      check({who, "_v_act"},  32'(d_vact), 32'd0);
      check({who, "_h_tot"},  32'(d_htot), 32'd0);
      check({who, "_v_tot"},  32'(d_vtot), 32'd0);
      check({who, "_csum"},   32'(d_csum), 32'd0);
      check({who, "_err"},    32'(d_err),  32'd0);
      check({who, "_locked"}, 32'(d_lock), 32'd0);
      check({who, "_inv_done"}, 32'(i_done), 32'd0);
      check({who, "_inv_sum"},
            32'(i_hact) + 32'(i_vact) + 32'(i_htot) + 32'(i_vtot) + 32'(i_csum)
            + 32'(i_err) + 32'(i_lock), 32'd0);
   endtask

   // One frame: hsync asserted for clocks 0..2 of every line, vsync for lines
   // 0..1, active lines start at line 2, DEN placed at a random offset.
   task automatic send_frame(input int h_len, input int n_lines, input int n_act,
                             input int den_len, input bit rand_pix,
                             input int rst_line, input int clr_line, input bit clr_edge);
      exp_t        cur;
      int          den_start;
      bit          rst_hit;
      logic [15:0] w;
      if (prev_ok) begin
         prev_exp.clr_same = clr_edge;
         exp_q.push_back(prev_exp);
         n_pushed++;
      end
      cur.h_act    = (n_act > 0) ? ((den_len > 2047) ? 2047 : den_len) : 0;
      cur.v_act    = n_act;
      cur.h_tot    = (h_len > 2047) ? 2047 : h_len;
      cur.v_tot    = n_lines;
      cur.csum     = 16'd0;
      cur.clr_same = 1'b0;
      cur.mism     = {cur.v_tot != VT, cur.h_tot != HT, cur.v_act != VA, cur.h_act != HA};
      rst_hit      = 1'b0;
      den_start    = 3 + int'($urandom_range(h_len - 3 - den_len, 0));
      for (int y = 0; y < n_lines; y++) begin
         for (int x = 0; x < h_len; x++) begin
            hs_n = (x >= 3);
            vs_n = (y >= 2);
            den  = (y >= 2) && (y < 2 + n_act) && (x >= den_start) && (x < den_start + den_len);
            w    = rand_pix ? 16'($urandom) : 16'h0001;
            pix  = w;
            if (den) cur.csum = cur.csum + w;
            if (y == 0 && x == 0) vs_drive_cyc = cyc;
            err_clr = (clr_edge && y == 0 && x == 1) || (y == clr_line && x == 0);
            if (y == clr_line && x == 3) begin
               err_model = 4'd0;
               check("err_after_clr", 32'(d_err), 32'd0);
               check("locked_after_clr", 32'(d_lock), 32'(locked_model));
               if (inv_check) check("inv_err_after_clr", 32'(i_err), 32'd0);
            end
            if (y == rst_line && x == 0) begin
               rst_n = 1'b0;
               #1;
               check_all_zero("midrst");
               check("queue_empty_at_rst", 32'(exp_q.size()), 32'd0);
               exp_q.delete();
               err_model    = 4'd0;
               locked_model = 1'b0;
               rst_hit      = 1'b1;
            end
            if (y == rst_line && x == 1) begin
               rst_n     = 1'b1;
               inv_check = 1'b1;
            end
            @(posedge clk);
            #1;
         end
      end
      prev_exp = cur;
      prev_ok  = !rst_hit;
   endtask

   // Result monitor: every frame_done pulse must match the oldest expected frame.
   always @(negedge clk) begin
      if (d_done) begin
         n_done++;
         check("done_width", 32'(prev_done), 32'd0);
         check("done_latency", cyc - vs_drive_cyc, 32'd2);
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e        = exp_q.pop_front();
            err_model    = mon_e.clr_same ? mon_e.mism : (err_model | mon_e.mism);
            locked_model = (mon_e.mism == 4'd0);
            check("h_active", 32'(d_hact), mon_e.h_act);
            check("v_active", 32'(d_vact), mon_e.v_act);
            check("h_total",  32'(d_htot), mon_e.h_tot);
            check("v_total",  32'(d_vtot), mon_e.v_tot);
            check("csum",     32'(d_csum), 32'(mon_e.csum));
            check("err",      32'(d_err),  32'(err_model));
            check("locked",   32'(d_lock), 32'(locked_model));
            if (inv_check) begin
               check("inv_h_active", 32'(i_hact), mon_e.h_act);
               check("inv_v_active", 32'(i_vact), mon_e.v_act);
               check("inv_h_total",  32'(i_htot), mon_e.h_tot);
               check("inv_v_total",  32'(i_vtot), mon_e.v_tot);
               check("inv_csum",     32'(i_csum), 32'(mon_e.csum));
               check("inv_err",      32'(i_err),  32'(err_model));
               check("inv_locked",   32'(i_lock), 32'(locked_model));
            end
         end
      end
      if (inv_check && (d_done || i_done)) check("inv_frame_done", 32'(i_done), 32'(d_done));
      prev_done = d_done;
   end

   initial begin
      rst_n   = 1'b0;
      hs_n    = 1'b1;
      vs_n    = 1'b1;
      den     = 1'b0;
      pix     = 16'd0;
      err_clr = 1'b0;
      inv_sel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Nominal timing with pixel word 0x0001: two reported frames
      repeat (3) send_frame(HT, VT, VA, HA, 1'b0, -1, -1, 1'b0);

      // Short lines; clear the error mid-frame, the next close sets it again
      send_frame(HT - 1, VT, VA, HA, 1'b1, -1, -1, 1'b0);
      send_frame(HT - 1, VT, VA, HA, 1'b1, -1, 4, 1'b0);

      // One active line missing
      send_frame(HT, VT, VA - 1, HA, 1'b1, -1, 4, 1'b0);
      send_frame(HT, VT, VA - 1, HA, 1'b1, -1, 4, 1'b0);

      // Clear coincident with a mismatching frame close: the set wins
      send_frame(HT, VT, VA, HA, 1'b1, -1, -1, 1'b1);

      // Over-long lines: pixel and DEN counters saturate at 2047
      send_frame(2100, VT, VA, 2097, 1'b1, -1, -1, 1'b0);

      // Wrong polarity on the SYNC_POL=1 monitor must raise an error
      inv_check = 1'b0;
      inv_sel   = 1'b1;
      repeat (2) send_frame(HT, VT, VA, HA, 1'b1, -1, -1, 1'b0);
      check("pol_mismatch_err", 32'(i_err != 4'd0), 32'd1);

      // Reset in the middle of a frame, then two more frames
      inv_sel = 1'b0;
      send_frame(HT, VT, VA, HA, 1'b1, 5, -1, 1'b0);
      repeat (2) send_frame(HT, VT, VA, HA, 1'b1, -1, -1, 1'b0);

      repeat (4) @(posedge clk);
      #1;
      check("done_count", n_done, n_pushed);
      check("final_err", 32'(d_err), 32'(err_model));
      check("final_locked", 32'(d_lock), 32'(locked_model));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
